fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 18 +
 rtl/fetch_unit.sv | 119 +++++++++++
 tb/tb_fetch_unit.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared core definitions for the instruction fetch stage: state encoding,
// reset vector default and the canonical NOP word.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD         = 32'h0000_0013;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch stage with branch redirect, decode
// back-pressure and a one-deep output register feeding decode.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        do_branch,
  input  logic [31:0] branch_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        flush,
  output logic        misaligned
);

  fetch_state_e state, state_d;
  logic [31:0]  pc, pc_d;
  logic [31:0]  issued_pc, issued_pc_d;
  logic         discard, discard_d;
  logic         if_valid_d;
  logic [31:0]  if_instr_d, if_pc_d;
  logic         misaligned_d;

  always_comb begin
    state_d      = state;
    pc_d         = pc;
    issued_pc_d  = issued_pc;
    discard_d    = discard;
    if_valid_d   = if_valid & stall;
    if_instr_d   = if_instr;
    if_pc_d      = if_pc;
    misaligned_d = 1'b0;
    imem_req     = 1'b0;
    imem_addr    = pc;
    flush        = 1'b0;

    case (state)
      FETCH: begin
        // Never issue while a held instruction could collide with the reply.
        if (if_valid && stall) begin
          state_d = HOLD;
        end else begin
          imem_req = 1'b1;
          if (imem_gnt) begin
            issued_pc_d = pc;
            state_d     = WAIT;
          end
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_d   = FETCH;
          discard_d = 1'b0;
          if (!discard) begin
            if_valid_d = 1'b1;
            if_instr_d = imem_rdata;
            if_pc_d    = issued_pc;
            pc_d       = issued_pc + 32'd4;
          end
        end
      end
      HOLD: begin
        if (!stall) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase

    if (do_branch) begin
      flush        = 1'b1;
      if_valid_d   = 1'b0;
      pc_d         = word_align(branch_target);
      misaligned_d = |branch_target[1:0];
      // An in-flight request must still be drained before re-issuing.
      if (state == WAIT)
        discard_d = !imem_rvalid;
      else if (state == FETCH && imem_req && imem_gnt)
        discard_d = 1'b1;
      else
        state_d = FETCH;
    end

    if (rst) begin
      imem_req = 1'b0;
      flush    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      issued_pc  <= 32'd0;
      discard    <= 1'b0;
      if_valid   <= 1'b0;
      if_instr   <= 32'd0;
      if_pc      <= 32'd0;
      misaligned <= 1'b0;
    end else begin
      state      <= state_d;
      pc         <= pc_d;
      issued_pc  <= issued_pc_d;
      discard    <= discard_d;
      if_valid   <= if_valid_d;
      if_instr   <= if_instr_d;
      if_pc      <= if_pc_d;
      misaligned <= misaligned_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: scoreboarded request addresses and delivered
// instructions, plus cycle-exact checks around stalls, redirects and reset.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        do_branch = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic        stall = 1'b0;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'd0;
  logic        if_valid, flush, misaligned;
  logic [31:0] if_instr, if_pc;

  logic        req2, rv2 = 1'b0, ifv2, fl2, mis2;
  logic        gnt2 = 1'b1;
  logic [31:0] addr2, ifi2, ifp2;
  logic [31:0] rdata2 = 32'd0;

  logic [31:0] exp_addr[$];
  fetch_t      exp_fetch[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned gnt_budget = 0;
  int unsigned gnt_used = 0;
  int          lat = 1;
  int          cnt = 0;
  logic [31:0] paddr = 32'd0;
  logic        rv = 1'b0;
  logic [31:0] ea;
  fetch_t      ef;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst(rst), .do_branch(do_branch), .branch_target(branch_target),
    .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .if_valid(if_valid),
    .if_instr(if_instr), .if_pc(if_pc), .flush(flush), .misaligned(misaligned)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .do_branch(do_branch), .branch_target(branch_target),
    .stall(stall), .imem_req(req2), .imem_addr(addr2), .imem_gnt(gnt2),
    .imem_rvalid(rv2), .imem_rdata(rdata2), .if_valid(ifv2),
    .if_instr(ifi2), .if_pc(ifp2), .flush(fl2), .misaligned(mis2)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  // Memory: grants while budget remains, answers after 'lat' cycles.
  assign imem_gnt    = gnt_used < gnt_budget;
  assign imem_rvalid = rv;

  always @(posedge clk) begin
    rv <= 1'b0;
    if (cnt == 1) begin
      rv <= 1'b1;
      imem_rdata <= mem_word(paddr);
    end
    if (cnt != 0) cnt <= cnt - 1;
    if (imem_req && imem_gnt) begin
      gnt_used <= gnt_used + 1;
      if (lat == 1) begin
        rv <= 1'b1;
        imem_rdata <= mem_word(imem_addr);
      end else begin
        cnt   <= lat - 1;
        paddr <= imem_addr;
      end
    end
  end

  always @(posedge clk) begin
    rv2    <= req2;
    rdata2 <= mem_word(addr2);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    nxt();
    nxt();
    rst = 1'b0;
  endtask

  task automatic push(input logic [31:0] a, input bit delivered);
    exp_addr.push_back(a);
    if (delivered) exp_fetch.push_back('{pc: a, instr: mem_word(a)});
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && (exp_addr.size() != 0 || exp_fetch.size() != 0); i++) nxt();
    chk({tag, "_addr_left"}, exp_addr.size(), 32'd0);
    chk({tag, "_fetch_left"}, exp_fetch.size(), 32'd0);
  endtask

  // Scoreboard monitor: every granted request and every consumed instruction.
  always @(negedge clk) begin
    if (!rst) begin
      if (imem_req && imem_gnt) begin
        chk("req_expected", {31'd0, exp_addr.size() != 0}, 32'd1);
        if (exp_addr.size() != 0) begin
          ea = exp_addr.pop_front();
          chk("req_addr", imem_addr, ea);
        end
      end
      if (if_valid && !stall && !flush) begin
        chk("fetch_expected", {31'd0, exp_fetch.size() != 0}, 32'd1);
        if (exp_fetch.size() != 0) begin
          ef = exp_fetch.pop_front();
          chk("fetch_pc", if_pc, ef.pc);
          chk("fetch_instr", if_instr, ef.instr);
        end
      end
    end
  end

  initial begin
    // Reset values, with a misaligned redirect that reset must override.
    do_branch = 1'b1;
    branch_target = 32'h123;
    nxt(); nxt();
    smp();
    chk("rst_req", imem_req, 0);
    chk("rst_flush", flush, 0);
    chk("rst_valid", if_valid, 0);
    chk("rst_instr", if_instr, 0);
    chk("rst_pc", if_pc, 0);
    chk("rst_mis", misaligned, 0);
    chk("rst_req2", req2, 0);
    nxt();
    rst = 1'b0;
    do_branch = 1'b0;
    push(32'h0, 1); push(32'h4, 1); push(32'h8, 1);
    gnt_budget += 3;
    smp();
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, 32'h0);
    chk("wrap_first_addr", addr2, 32'hFFFF_FFFC);
    nxt(); smp();
    chk("lat_valid_c1", if_valid, 0);
    chk("lat_req_c1", imem_req, 0);
    nxt(); smp();
    chk("lat_valid_c2", if_valid, 1);
    chk("lat_pc_c2", if_pc, 32'h0);
    chk("wrap_second_req", req2, 1);
    chk("wrap_second_addr", addr2, 32'h0);
    chk("wrap_if_pc", ifp2, 32'hFFFF_FFFC);
    drain("seq");

    // Stall holds the output register and blocks new requests.
    do_reset();
    push(32'h0, 1); push(32'h4, 1); push(32'h8, 1);
    gnt_budget += 3;
    nxt(); nxt(); nxt(); nxt();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("stall_valid", if_valid, 1);
      chk("stall_pc", if_pc, 32'h4);
      chk("stall_instr", if_instr, mem_word(32'h4));
      chk("stall_req", imem_req, 0);
      nxt();
    end
    stall = 1'b0;
    smp();
    chk("unstall_valid", if_valid, 1);
    drain("stall");

    // Redirect coinciding with the response in WAIT drops that response.
    do_reset();
    push(32'h0, 1); push(32'h4, 1); push(32'h8, 0); push(32'h100, 1);
    gnt_budget += 4;
    nxt(); nxt(); nxt(); nxt(); nxt();
    do_branch = 1'b1;
    branch_target = 32'h100;
    smp();
    chk("br_wait_flush", flush, 1);
    chk("br_wait_req", imem_req, 0);
    nxt();
    do_branch = 1'b0;
    smp();
    chk("br_wait_flush_off", flush, 0);
    chk("br_wait_valid", if_valid, 0);
    chk("br_wait_addr", imem_addr, 32'h100);
    drain("br_wait");

    // Redirect before the response arrives: response discarded later.
    lat = 2;
    do_reset();
    push(32'h0, 0); push(32'h200, 1);
    gnt_budget += 2;
    nxt();
    do_branch = 1'b1;
    branch_target = 32'h200;
    smp();
    chk("disc_flush", flush, 1);
    nxt();
    do_branch = 1'b0;
    smp();
    chk("disc_req_wait", imem_req, 0);
    chk("disc_mis", misaligned, 0);
    nxt(); smp();
    chk("disc_valid", if_valid, 0);
    chk("disc_req", imem_req, 1);
    chk("disc_addr", imem_addr, 32'h200);
    drain("disc");
    lat = 1;

    // Misaligned redirect in FETCH while the request is being granted.
    do_reset();
    push(32'h0, 0); push(32'h100, 1);
    gnt_budget += 2;
    do_branch = 1'b1;
    branch_target = 32'h102;
    smp();
    chk("mis_flush", flush, 1);
    chk("mis_pre", misaligned, 0);
    nxt();
    do_branch = 1'b0;
    smp();
    chk("mis_pulse", misaligned, 1);
    chk("mis_req_wait", imem_req, 0);
    chk("mis_valid", if_valid, 0);
    nxt(); smp();
    chk("mis_clear", misaligned, 0);
    chk("mis_req", imem_req, 1);
    chk("mis_addr", imem_addr, 32'h100);
    chk("mis_valid2", if_valid, 0);
    drain("mis");

    // Redirect out of HOLD overrides the held instruction.
    do_reset();
    push(32'h0, 0); push(32'h40, 1);
    gnt_budget += 2;
    nxt(); nxt();
    stall = 1'b1;
    smp();
    chk("hold_valid", if_valid, 1);
    chk("hold_pc", if_pc, 32'h0);
    nxt();
    do_branch = 1'b1;
    branch_target = 32'h40;
    stall = 1'b0;
    smp();
    chk("hold_flush", flush, 1);
    chk("hold_req", imem_req, 0);
    nxt();
    do_branch = 1'b0;
    smp();
    chk("hold_valid_clr", if_valid, 0);
    chk("hold_addr", imem_addr, 32'h40);
    drain("hold");

    // Reset during WAIT; the orphan response lands in the first FETCH cycle.
    lat = 2;
    do_reset();
    push(32'h0, 0);
    gnt_budget += 1;
    nxt();
    rst = 1'b1;
    smp();
    chk("rwait_req_rst", imem_req, 0);
    nxt();
    rst = 1'b0;
    lat = 1;
    smp();
    chk("rwait_req", imem_req, 1);
    chk("rwait_addr", imem_addr, 32'h0);
    chk("rwait_valid0", if_valid, 0);
    nxt();
    push(32'h0, 1);
    gnt_budget += 1;
    smp();
    chk("rwait_valid1", if_valid, 0);
    drain("rwait");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
